enemy_bullet_gen: RTL and testbench
===================================

Name: enemy_bullet_gen

Overview:
- Upstream producer of the enemy_bullet_X / enemy_bullet_Y pair consumed by the player display/collision stage (DisplayObj).
- Owns one enemy bullet: periodically spawns it below the enemy sprite, aims it toward the player column, steps it down the 320x240 screen at a frame-rate tick, and retires it on screen exit or on a hit report from DisplayObj.
- Parks the bullet off-screen whenever it is inactive.

Parameters:
- SCREEN_W, 320, visible width in pixels.
- SCREEN_H, 240, visible height in pixels.
- TICK_DIV, 833333, CLOCK_50 cycles per movement step (60 Hz).
- FIRE_PERIOD, 30, steps of cooldown between retire/enable and the next spawn (>=1).
- BULLET_STEP, 2, pixels moved down per step (1..15).
- SPAWN_X_OFF, 8, X offset from enemy_X to the spawn point.
- SPAWN_Y_OFF, 12, Y offset from enemy_Y to the spawn point.

Ports:
- CLOCK_50  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  game running; low freezes and parks the bullet.
- game_over_en  in  1  from DisplayObj; high forces IDLE.
- enemy_X  in  9  enemy sprite origin X.
- enemy_Y  in  8  enemy sprite origin Y.
- player_X  in  9  player origin X, used for aiming.
- hit  in  1  one-cycle pulse from DisplayObj: the bullet struck the player.
- enemy_bullet_X  out  9  bullet X; 9'h1FF when parked.
- enemy_bullet_Y  out  8  bullet Y; 8'hFF when parked.
- bullet_active  out  1  bullet is on screen.
- step_pulse  out  1  one-cycle movement tick.
- shot_count  out  8  spawned-bullet counter; wraps 255->0.

Behaviour:
- **Reset** (rst=1 at a clock edge):
  - state=IDLE, tick counter=0, cooldown=0, dir=0.
  - Outputs: X=9'h1FF, Y=8'hFF, bullet_active=0, step_pulse=0, shot_count=0.
  - Reset mid-flight aborts the bullet on that edge.
- **Tick counter**:
  - Counts 0..TICK_DIV-1 while enable=1 and game_over_en=0; otherwise held at 0.
  - step_pulse is registered and high for exactly the cycle after the counter wraps, giving one pulse per TICK_DIV cycles.
- **IDLE**:
  - Bullet parked.
  - When enable=1 and game_over_en=0: go to COOLDOWN with cooldown=FIRE_PERIOD.
- **COOLDOWN**:
  - Each step_pulse decrements cooldown.
  - On a step_pulse with cooldown==1, compute the spawn point sx = enemy_X+SPAWN_X_OFF and sy = enemy_Y+SPAWN_Y_OFF, using a 10-bit sum.
  - If sx>=SCREEN_W or sy>=SCREEN_H: no spawn, reload cooldown=FIRE_PERIOD, stay in COOLDOWN.
  - Otherwise, on the next edge:
    - load X=sx, Y=sy;
    - set dir = -1 if player_X<sx, 0 if player_X==sx, +1 if player_X>sx;
    - bullet_active=1, shot_count+1, go to FLY.
- **FLY**, on each step_pulse:
  - Let ny = Y+BULLET_STEP (10-bit).
  - If ny>SCREEN_H-1: retire. Park the bullet, active=0, cooldown=FIRE_PERIOD, go to COOLDOWN.
  - Else Y=ny, and X=X+dir with edge saturation:
    - dir=-1 with X==0 sets dir=0 and holds X;
    - dir=+1 with X==SCREEN_W-1 sets dir=0 and holds X.
- **hit=1 in FLY**: retire on the next edge, exactly as a screen exit. hit has priority over a simultaneous step_pulse. hit is ignored in all other states.
- **Priority**: rst > game_over_en > enable=0 > hit > step.
  - game_over_en=1 or enable=0 in any state: IDLE on the next edge, bullet parked.
  - shot_count is retained; only rst clears it.
- **Timing**: enemy_X, enemy_Y and player_X are sampled only at spawn. Later changes do not affect a bullet already in flight.
- **Registers**: all outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan (TICK_DIV=4, FIRE_PERIOD=3, BULLET_STEP=2, SPAWN offsets 8/12, SCREEN 320x240):
- Reset then hold:
  - Stimulus: rst=1 for 2 cycles, then rst=0 with enable=0 for 20 cycles.
  - Required: X=511, Y=255, active=0, step_pulse never asserted, shot_count=0.
- Spawn and straight flight:
  - Stimulus: enable=1, enemy=(100,20), player_X=108.
  - Required: spawn (108,32) on the edge after the 3rd step_pulse; active=1; shot_count=1. The next two steps give (108,34) then (108,36). step_pulse spacing is exactly 4 cycles.
- Aim with edge saturation:
  - Stimulus: enemy=(311,20), player_X=0 gives spawn sx=319, dir=-1; X steps 318, 317, …
  - Stimulus: enemy=(311,20), player_X=400 gives spawn sx=319, dir=+1; X holds at 319 while Y still increments by 2.
- Screen exit:
  - Stimulus: a bullet at Y=238.
  - Required: on the next step it retires (ny=240>239); parked (511,255); active=0. The next spawn follows exactly 3 steps later.
- Hit pulse coincident with step_pulse:
  - Required: bullet parked on the next edge with Y unchanged by that step; cooldown reloads to 3.
- Game over mid-flight:
  - Stimulus: game_over_en=1 while in FLY.
  - Required: next edge parks the bullet and enters IDLE; the tick counter holds at 0; shot_count is retained.
  - Stimulus: then rst=1.
  - Required: shot_count=0.

Source files
------------

// File: rtl/enemy_bullet_gen.sv
// ============================================================================
// Module   : enemy_bullet_gen
// Purpose  : Single enemy bullet: periodic spawn below the enemy, aim at the
//            player column, frame-tick descent, retire on exit or hit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module enemy_bullet_gen #(
    parameter int SCREEN_W    = 320,
    parameter int SCREEN_H    = 240,
    parameter int TICK_DIV    = 833333,
    parameter int FIRE_PERIOD = 30,
    parameter int BULLET_STEP = 2,
    parameter int SPAWN_X_OFF = 8,
    parameter int SPAWN_Y_OFF = 12
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       enable,
    input  logic       game_over_en,
    input  logic [8:0] enemy_X,
    input  logic [7:0] enemy_Y,
    input  logic [8:0] player_X,
    input  logic       hit,
    output logic [8:0] enemy_bullet_X,
    output logic [7:0] enemy_bullet_Y,
    output logic       bullet_active,
    output logic       step_pulse,
    output logic [7:0] shot_count
);

    localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CDW = $clog2(FIRE_PERIOD + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COOLDOWN = 2'd1,
        S_FLY      = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [TCW-1:0]   tick_q;
    logic             step_q;
    logic [CDW-1:0]   cd_q, cd_d;
    logic [1:0]       dir_q, dir_d;
    logic [8:0]       x_q, x_d;
    logic [7:0]       y_q, y_d;
    logic             active_q, active_d;
    logic [7:0]       shots_q, shots_d;

    logic             run_w;
    logic [9:0]       sx_w, sy_w, ny_w;

    assign run_w = enable && !game_over_en;
    assign sx_w  = {1'b0, enemy_X} + 10'(SPAWN_X_OFF);
    assign sy_w  = {2'b0, enemy_Y} + 10'(SPAWN_Y_OFF);
    assign ny_w  = {2'b0, y_q} + 10'(BULLET_STEP);

    always_ff @(posedge CLOCK_50) begin
        if (rst || !run_w) begin
            tick_q <= '0;
            step_q <= 1'b0;
        end else begin
            step_q <= (tick_q == TCW'(TICK_DIV - 1));
            tick_q <= (tick_q == TCW'(TICK_DIV - 1)) ? '0 : tick_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cd_d     = cd_q;
        dir_d    = dir_q;
        x_d      = x_q;
        y_d      = y_q;
        active_d = active_q;
        shots_d  = shots_q;

        if (!run_w) begin
            state_d  = S_IDLE;
            x_d      = 9'h1FF;
            y_d      = 8'hFF;
            active_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_COOLDOWN;
                    cd_d    = CDW'(FIRE_PERIOD);
                end
                S_COOLDOWN: begin
                    if (step_q) begin
                        if (cd_q > CDW'(1)) begin
                            cd_d = cd_q - 1'b1;
                        end else if (sx_w >= 10'(SCREEN_W) || sy_w >= 10'(SCREEN_H)) begin
                            cd_d = CDW'(FIRE_PERIOD);
                        end else begin
                            x_d      = sx_w[8:0];
                            y_d      = sy_w[7:0];
                            active_d = 1'b1;
                            shots_d  = shots_q + 8'd1;
                            state_d  = S_FLY;
                            if (player_X < sx_w[8:0])
                                dir_d = 2'b11;
                            else if (player_X == sx_w[8:0])
                                dir_d = 2'b00;
                            else
                                dir_d = 2'b01;
                        end
                    end
                end
                S_FLY: begin
                    // hit outranks the movement step; both retire identically
                    if (hit || (step_q && ny_w > 10'(SCREEN_H - 1))) begin
                        x_d      = 9'h1FF;
                        y_d      = 8'hFF;
                        active_d = 1'b0;
                        cd_d     = CDW'(FIRE_PERIOD);
                        state_d  = S_COOLDOWN;
                    end else if (step_q) begin
                        y_d = ny_w[7:0];
                        if (dir_q == 2'b11) begin
                            if (x_q == 9'd0) dir_d = 2'b00;
                            else             x_d   = x_q - 9'd1;
                        end else if (dir_q == 2'b01) begin
                            if (x_q == 9'(SCREEN_W - 1)) dir_d = 2'b00;
                            else                         x_d   = x_q + 9'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cd_q     <= '0;
            dir_q    <= 2'b00;
            x_q      <= 9'h1FF;
            y_q      <= 8'hFF;
            active_q <= 1'b0;
            shots_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            cd_q     <= cd_d;
            dir_q    <= dir_d;
            x_q      <= x_d;
            y_q      <= y_d;
            active_q <= active_d;
            shots_q  <= shots_d;
        end
    end

    assign enemy_bullet_X = x_q;
    assign enemy_bullet_Y = y_q;
    assign bullet_active  = active_q;
    assign step_pulse     = step_q;
    assign shot_count     = shots_q;

endmodule

`default_nettype wire

// File: tb/tb_enemy_bullet_gen.sv
// ============================================================================
// Module   : tb_enemy_bullet_gen
// Purpose  : Scoreboard bench for enemy_bullet_gen with directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enemy_bullet_gen;

    logic       CLOCK_50 = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       game_over_en = 1'b0;
    logic       hit = 1'b0;
    logic [8:0] enemy_X = '0;
    logic [7:0] enemy_Y = '0;
    logic [8:0] player_X = '0;
    logic [8:0] enemy_bullet_X;
    logic [7:0] enemy_bullet_Y;
    logic       bullet_active;
    logic       step_pulse;
    logic [7:0] shot_count;

    int          checks = 0;
    int          failures = 0;
    logic [25:0] exp_q[$];
    logic        mon_on = 1'b0;

    enemy_bullet_gen #(
        .SCREEN_W(320), .SCREEN_H(240), .TICK_DIV(4), .FIRE_PERIOD(3),
        .BULLET_STEP(2), .SPAWN_X_OFF(8), .SPAWN_Y_OFF(12)
    ) dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .enable(enable),
        .game_over_en(game_over_en), .enemy_X(enemy_X), .enemy_Y(enemy_Y),
        .player_X(player_X), .hit(hit), .enemy_bullet_X(enemy_bullet_X),
        .enemy_bullet_Y(enemy_bullet_Y), .bullet_active(bullet_active),
        .step_pulse(step_pulse), .shot_count(shot_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [25:0] pk(int x, int y, int a, int s);
        return {9'(x), 8'(y), 1'(a), 8'(s)};
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Pops one expected state whenever the visible bullet state changes.
    task automatic monitor();
        logic [25:0] cur, prev, e;
        bit armed;
        armed = 1'b0;
        prev  = '0;
        forever begin
            @(negedge CLOCK_50);
            if (!mon_on) begin
                armed = 1'b0;
            end else begin
                cur = {enemy_bullet_X, enemy_bullet_Y, bullet_active, shot_count};
                if (!armed) begin
                    prev  = cur;
                    armed = 1'b1;
                end else if (cur != prev) begin
                    prev = cur;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output actual=(%0d,%0d,%0d,%0d) required=none",
                                 cur[25:17], cur[16:9], cur[8], cur[7:0]);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur != e) begin
                            failures++;
                            $display("FAIL bullet_state actual=(%0d,%0d,%0d,%0d) required=(%0d,%0d,%0d,%0d)",
                                     cur[25:17], cur[16:9], cur[8], cur[7:0],
                                     e[25:17], e[16:9], e[8], e[7:0]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_step(output int cyc);
        cyc = 0;
        do begin
            @(negedge CLOCK_50);
            cyc++;
        end while (!step_pulse && cyc < 200);
        if (!step_pulse) begin
            checks++;
            failures++;
            $display("FAIL step_timeout actual=%0d cycles required=step_pulse", cyc);
        end
    endtask

    task automatic spawn_check(string name);
        int c;
        for (int i = 0; i < 3; i++) begin
            wait_step(c);
            if (i > 0) check({name, "_step_gap"}, c, 4);
        end
        check({name, "_pre_spawn_active"}, int'(bullet_active), 0);
        @(negedge CLOCK_50);
        check({name, "_spawn_active"}, int'(bullet_active), 1);
    endtask

    task automatic park_out();
        @(negedge CLOCK_50);
        enable = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    initial begin
        int c;
        bit sp;
        fork
            monitor();
        join_none

        repeat (2) @(negedge CLOCK_50);
        rst = 1'b0;
        sp  = 1'b0;
        repeat (20) begin
            @(negedge CLOCK_50);
            if (step_pulse) sp = 1'b1;
        end
        check("idle_step_pulse", int'(sp), 0);
        check("reset_X", int'(enemy_bullet_X), 511);
        check("reset_Y", int'(enemy_bullet_Y), 255);
        check("reset_active", int'(bullet_active), 0);
        check("reset_shots", int'(shot_count), 0);
        mon_on = 1'b1;
        @(negedge CLOCK_50);

        // straight flight; inputs changed in flight must not matter
        enemy_X = 9'd100; enemy_Y = 8'd20; player_X = 9'd108;
        exp_q.push_back(pk(108, 32, 1, 1));
        exp_q.push_back(pk(108, 34, 1, 1));
        exp_q.push_back(pk(108, 36, 1, 1));
        exp_q.push_back(pk(511, 255, 0, 1));
        enable = 1'b1;
        spawn_check("straight");
        enemy_X = 9'd0; enemy_Y = 8'd0; player_X = 9'd0;
        wait_step(c);
        wait_step(c);
        check("fly_step_gap", c, 4);
        park_out();

        // aim left from the right edge
        enemy_X = 9'd311; enemy_Y = 8'd20; player_X = 9'd0;
        exp_q.push_back(pk(319, 32, 1, 2));
        exp_q.push_back(pk(318, 34, 1, 2));
        exp_q.push_back(pk(317, 36, 1, 2));
        exp_q.push_back(pk(511, 255, 0, 2));
        enable = 1'b1;
        spawn_check("aim_left");
        wait_step(c);
        wait_step(c);
        park_out();

        // aim right at the right edge saturates
        player_X = 9'd400;
        exp_q.push_back(pk(319, 32, 1, 3));
        exp_q.push_back(pk(319, 34, 1, 3));
        exp_q.push_back(pk(319, 36, 1, 3));
        exp_q.push_back(pk(511, 255, 0, 3));
        enable = 1'b1;
        spawn_check("aim_right");
        wait_step(c);
        wait_step(c);
        park_out();

        // spawn point below the screen never spawns
        enemy_X = 9'd100; enemy_Y = 8'd230; player_X = 9'd108;
        enable = 1'b1;
        repeat (7) wait_step(c);
        check("oob_spawn_active", int'(bullet_active), 0);
        park_out();

        // screen exit from Y=238, then respawn after exactly three steps
        enemy_Y = 8'd226;
        exp_q.push_back(pk(108, 238, 1, 4));
        exp_q.push_back(pk(511, 255, 0, 4));
        exp_q.push_back(pk(108, 238, 1, 5));
        exp_q.push_back(pk(511, 255, 0, 5));
        enable = 1'b1;
        spawn_check("exit");
        wait_step(c);
        @(negedge CLOCK_50);
        check("exit_retire_active", int'(bullet_active), 0);
        spawn_check("exit_respawn");
        wait_step(c);
        @(negedge CLOCK_50);
        check("exit2_retire_active", int'(bullet_active), 0);
        park_out();

        // hit coincident with a step
        enemy_Y = 8'd20;
        exp_q.push_back(pk(108, 32, 1, 6));
        exp_q.push_back(pk(511, 255, 0, 6));
        exp_q.push_back(pk(108, 32, 1, 7));
        exp_q.push_back(pk(511, 255, 0, 7));
        enable = 1'b1;
        spawn_check("hit_pre");
        wait_step(c);
        hit = 1'b1;
        @(negedge CLOCK_50);
        hit = 1'b0;
        check("hit_retire_active", int'(bullet_active), 0);
        spawn_check("hit_respawn");

        // game over mid-flight
        @(negedge CLOCK_50);
        game_over_en = 1'b1;
        @(negedge CLOCK_50);
        sp = 1'b0;
        repeat (12) begin
            @(negedge CLOCK_50);
            if (step_pulse) sp = 1'b1;
        end
        check("gameover_step_pulse", int'(sp), 0);
        check("gameover_active", int'(bullet_active), 0);
        check("gameover_shots", int'(shot_count), 7);

        mon_on = 1'b0;
        rst = 1'b1;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_shots", int'(shot_count), 0);
        check("rst_X", int'(enemy_bullet_X), 511);
        check("queue_drained", exp_q.size(), 0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
